// File: rtl/mem_arbiter_n.sv
// Memory-side arbiter for N cache ports sharing one pipelined main memory.
// Serves aligned line fills (one address per cycle) and single-word write-through.
module mem_arbiter_n #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 8,
  parameter int RR_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_PORTS-1:0]            req,
  input  logic [N_PORTS-1:0]            wr,
  input  logic [N_PORTS*ADDR_W-1:0]     addr,
  input  logic [N_PORTS*DATA_W-1:0]     wdata,
  output logic [N_PORTS-1:0]            gnt,
  output logic [N_PORTS-1:0]            resp_valid,
  output logic [DATA_W-1:0]             resp_data,
  output logic [$clog2(LINE_WORDS)-1:0] resp_idx,
  output logic [N_PORTS-1:0]            done,
  output logic                          mem_en,
  output logic                          mem_wr,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_valid
);
  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_r, state_nx_s;
  logic [PORT_W-1:0]   rr_ptr_r, rr_ptr_nx_s, search_start_s, win_idx_s;
  logic                win_found_s;
  logic [N_PORTS-1:0]  gnt_r;
  logic [ADDR_W-1:0]   addr_r, line_off_s;
  logic [DATA_W-1:0]   wdata_r;
  logic [CNT_W-1:0]    issue_cnt_r, ret_cnt_r;
  logic                ret_valid_s;
  logic [ADDR_W-1:0]   addr_arr_s  [N_PORTS];
  logic [DATA_W-1:0]   wdata_arr_s [N_PORTS];

  // First requester found scanning upward from start, wrapping at N_PORTS.
  function automatic logic [PORT_W:0] pick_winner(input logic [N_PORTS-1:0] reqs,
                                                  input logic [PORT_W-1:0]  start);
    logic              found;
    logic [PORT_W-1:0] idx;
    logic [PORT_W-1:0] cand;
    int                j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      j = int'(start) + i;
      if (j >= N_PORTS) begin
        j = j - N_PORTS;
      end
      cand = PORT_W'(j);
      if (!found && reqs[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
    assign addr_arr_s[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr_s[g] = wdata[g*DATA_W +: DATA_W];
  end

  assign search_start_s = (RR_MODE != 0) ? rr_ptr_r : '0;
  assign {win_found_s, win_idx_s} = pick_winner(req, search_start_s);
  assign rr_ptr_nx_s = (win_idx_s == PORT_W'(N_PORTS - 1)) ? '0 : win_idx_s + PORT_W'(1);
  // Offset is OR-ed into the aligned base so the burst can never carry out of its line.
  assign line_off_s  = ADDR_W'({issue_cnt_r[IDX_W-1:0], 1'b0});
  assign ret_valid_s = mem_valid && ((state_r == ST_ISSUE) || (state_r == ST_DRAIN))
                       && (ret_cnt_r < CNT_W'(LINE_WORDS));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_nx_s = wr[win_idx_s] ? ST_WRITE : ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nx_s = (issue_cnt_r == CNT_W'(LINE_WORDS - 1)) ? ST_DRAIN : ST_ISSUE;
      ST_DRAIN: state_nx_s = (ret_cnt_r == CNT_W'(LINE_WORDS)) ? ST_DONE : ST_DRAIN;
      ST_WRITE: state_nx_s = ST_DONE;
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Grant, latched request, counters and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r       <= '0;
      addr_r      <= '0;
      wdata_r     <= '0;
      issue_cnt_r <= '0;
      ret_cnt_r   <= '0;
      rr_ptr_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            gnt_r       <= N_PORTS'(1) << win_idx_s;
            addr_r      <= addr_arr_s[win_idx_s];
            wdata_r     <= wdata_arr_s[win_idx_s];
            issue_cnt_r <= '0;
            ret_cnt_r   <= '0;
            if (RR_MODE != 0) begin
              rr_ptr_r <= rr_ptr_nx_s;
            end
          end
        end
        ST_ISSUE: issue_cnt_r <= issue_cnt_r + CNT_W'(1);
        ST_DONE:  gnt_r <= '0;
        default:  gnt_r <= gnt_r;
      endcase
      if (ret_valid_s) begin
        ret_cnt_r <= ret_cnt_r + CNT_W'(1);
      end
    end
  end

  // Output decode; fill words pass straight from memory to the owner.
  always_comb begin
    gnt       = gnt_r;
    done      = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_r)
      ST_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = (addr_r & ~LINE_MASK) | line_off_s;
      end
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
      end
      ST_DONE: done = gnt_r;
      default: done = '0;
    endcase
    if (ret_valid_s) begin
      resp_valid = gnt_r;
      resp_data  = mem_rdata;
      resp_idx   = ret_cnt_r[IDX_W-1:0];
    end else begin
      resp_valid = '0;
      resp_data  = '0;
      resp_idx   = '0;
    end
  end

endmodule
